afterburner_param: RTL
======================

// Module: afterburner_param
// PURPOSE
//  Parametrised 2x interpolator feeding a DDR DAC. Sample stream a1, k*(a1+a2), a2, ... with runtime-writable k.
//  Per clk it emits one pass-through sample and one scaled-average sample.
//  Sits between the digital upconverter output and the DDR output cells, which are instantiated elsewhere.
//  Adds generic widths, selectable tap spacing, runtime coefficient, bypass (sample repeat) and saturation reporting.
// PARAMETERS
//  IW     17      input sample width, signed
//  OW     16      output width; must be <= IW-1
//  CW     18      coefficient width, signed
//  COEFF  -20956  reset value of k, scaled by 2^15 (0.5*sec(2*pi*11/28) = -0.63952)
//  DSPAN  1       tap spacing of averaged pair; odd, 1..7 (1 = adjacent, 3 = triple)
//  SHIFT  16      product right shift before saturation
//  OBIN   1       1 = offset-binary outputs (MSB inverted), 0 = two's complement
// PORTS
//  clk        in   1    single clock, timespec 6.0 ns
//  rst        in   1    synchronous reset, active-high
//  data       in   IW   signed input sample, one per clk
//  coeff_in   in   CW   new k value
//  coeff_wr   in   1    load coeff_in into the active k register
//  bypass     in   1    1 = zero-order hold: data_out0 repeats data_out1
//  sat_clr    in   1    clear sat_count
//  data_out0  out  OW   interpolated sample (second DAC phase)
//  data_out1  out  OW   pass-through sample (first DAC phase)
//  sat_flag   out  1    registered; high for each output word that saturated
//  sat_count  out  16   saturation event counter
// BEHAVIOUR
//  Reset: all pipeline registers clear to 0; k <= COEFF; sat_flag 0; sat_count 0.
//   Outputs are registered value 0, i.e. 0x8000 when OBIN=1 and 0x0000 when OBIN=0.
//  Pipeline: x[n] enters at edge n.
//   Stage1 avg = x + x delayed DSPAN, IW+1 bits.
//   Stage2 prod = avg*k, IW+1+CW bits.
//   Stage3 sat.
//  Latency: data_out0 at cycle t = sat(k*(x[t-3]+x[t-3-DSPAN]) >>> SHIFT).
//   data_out1 at cycle t = x[t-3-(DSPAN-1)/2] >> (IW-OW) (arithmetic), so both outputs stay mutually aligned.
//  Saturation: if prod>>>SHIFT lies outside the signed OW range, clamp to +max/-min.
//   Clamp is exact, with no wrap. sat_flag registers with the same timing as data_out0.
//   Rounding is floor (truncation of two's complement).
//  coeff_wr: k updates at the edge where coeff_wr=1; the first product using the new k is formed at the next edge.
//   No glitch or mixed-coefficient output. rst on the same edge wins: k <= COEFF.
//  bypass: sampled in stage3.
//   When 1, stage3 loads the thru-aligned sample instead of the product, so data_out0 == data_out1 on that cycle.
//   sat_flag is 0. Toggling bypass causes no pipeline flush; the switch is effective from the next output word.
//  OBIN=1: MSB of both outputs inverted after saturation.
//  Reset mid-stream: outputs show midscale on the cycle after rst. Valid data resumes 3 cycles after rst deasserts.
//   The averaging delay line refills with zeros.
// CONFIGURATION
//  AFTERBURNER_SATCOUNT_EN defined: sat_count increments on each cycle sat_flag is set, saturating at 0xFFFF.
//   sat_clr wins over a simultaneous increment (result 0). Cleared by rst.
//  Undefined: counter logic is absent and sat_count is tied to 0; sat_clr is ignored. sat_flag exists in both builds.
// TESTING (defaults, OBIN=1)
//  rst held 4 cycles, data=1000 -> data_out0=0x8000, data_out1=0x8000, sat_flag=0 throughout.
//  Constant data=1000 after reset, k=-20956 -> from cycle 4: data_out0=0x7D80 (-640), data_out1=0x81F4 (500).
//  coeff_wr with coeff_in=32767, data=65535 -> data_out0=0xFFFF, sat_flag=1.
//   Then coeff_in=-32768 -> data_out0=0x0000, sat_flag=1. Each change lands exactly 2 cycles after the write.
//  Impulse data=4096 for one cycle, DSPAN=3 -> data_out1=0x8800 at cycle t+4 only.
//   data_out0 = -1310 (0x7AE2) at cycles t+3 and t+6.
//  bypass=1 with ramp input -> data_out0 == data_out1 every cycle, sat_flag=0. Deassert -> interpolated output next word.
//  SATCOUNT_EN: 5 saturating words -> sat_count=5; sat_clr during a saturating word -> 0.
//   Without macro: sat_count stays 0.

Source files
------------

// File: rtl/afterburner_param.sv
// afterburner_param: 2x interpolator for a DDR DAC.
// Every clock it emits one pass-through sample (data_out1) and one scaled
// average k*(x + x delayed by DSPAN) (data_out0). The two outputs stay aligned.
// Optional feature macro: AFTERBURNER_SATCOUNT_EN enables the saturation event
// counter. Without it, sat_count is tied to 0 and sat_clr is ignored.
// SHIFT must be at least 1. OW must be at most IW-1.
module afterburner_param #(
  parameter int IW    = 17,
  parameter int OW    = 16,
  parameter int CW    = 18,
  parameter int COEFF = -20956,
  parameter int DSPAN = 1,
  parameter int SHIFT = 16,
  parameter int OBIN  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [IW-1:0] data,
  input  logic signed [CW-1:0] coeff_in,
  input  logic                 coeff_wr,
  input  logic                 bypass,
  input  logic                 sat_clr,
  output logic [OW-1:0]        data_out0,
  output logic [OW-1:0]        data_out1,
  output logic                 sat_flag,
  output logic [15:0]          sat_count
);

  localparam int PW   = IW + 1 + CW;
  localparam int SW   = PW - SHIFT;
  localparam int CTAP = (DSPAN - 1) / 2;
  localparam logic [OW-1:0] MSB_FLIP = (OBIN != 0) ? {1'b1, {(OW-1){1'b0}}} : '0;
  localparam logic signed [SW-1:0] OMAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic signed [CW-1:0] K_RST = CW'(COEFF);

  logic signed [IW-1:0] dl_q [DSPAN+1];
  logic signed [IW-1:0] dl_d [DSPAN+1];
  logic signed [IW:0]   avg_q, avg_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [CW-1:0] k_q, k_d;
  logic [OW-1:0]        thru1_q, thru1_d;
  logic [OW-1:0]        thru2_q, thru2_d;
  logic [OW-1:0]        out0_q, out0_d;
  logic [OW-1:0]        out1_q, out1_d;
  logic                 sat_flag_q, sat_flag_d;
  logic signed [SW-1:0] scaled;
  logic [SHIFT-1:0]     unused_prod_lsb;

  // Next-state logic: delay line, average, product and saturating output stage.
  always_comb begin
    dl_d[0] = data;
    for (int i = 1; i <= DSPAN; i++) begin
      dl_d[i] = dl_q[i-1];
    end
    avg_d   = {dl_q[0][IW-1], dl_q[0]} + {dl_q[DSPAN][IW-1], dl_q[DSPAN]};
    // Sign-extended operands, so the low PW bits of the product are the signed product.
    prod_d  = {{CW{avg_q[IW]}}, avg_q} * {{(IW+1){k_q[CW-1]}}, k_q};
    k_d     = coeff_wr ? coeff_in : k_q;
    // The centre tap keeps the pass-through sample aligned with the averaged pair.
    thru1_d = dl_q[CTAP][IW-1 -: OW];
    thru2_d = thru1_q;
    out1_d  = thru2_q ^ MSB_FLIP;

    // The dropped product LSBs give floor rounding.
    scaled          = prod_q[PW-1:SHIFT];
    unused_prod_lsb = prod_q[SHIFT-1:0];
    sat_flag_d      = 1'b0;
    if (bypass) begin
      out0_d = thru2_q ^ MSB_FLIP;
    end else if (scaled > OMAX) begin
      out0_d     = OMAX[OW-1:0] ^ MSB_FLIP;
      sat_flag_d = 1'b1;
    end else if (scaled < OMIN) begin
      out0_d     = OMIN[OW-1:0] ^ MSB_FLIP;
      sat_flag_d = 1'b1;
    end else begin
      out0_d = scaled[OW-1:0] ^ MSB_FLIP;
    end
  end

  // Pipeline registers. Reset also wins over a simultaneous coefficient write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DSPAN; i++) begin
        dl_q[i] <= '0;
      end
      avg_q      <= '0;
      prod_q     <= '0;
      k_q        <= K_RST;
      thru1_q    <= '0;
      thru2_q    <= '0;
      out0_q     <= MSB_FLIP;
      out1_q     <= MSB_FLIP;
      sat_flag_q <= 1'b0;
    end else begin
      for (int i = 0; i <= DSPAN; i++) begin
        dl_q[i] <= dl_d[i];
      end
      avg_q      <= avg_d;
      prod_q     <= prod_d;
      k_q        <= k_d;
      thru1_q    <= thru1_d;
      thru2_q    <= thru2_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign data_out0 = out0_q;
  assign data_out1 = out1_q;
  assign sat_flag  = sat_flag_q;

`ifdef AFTERBURNER_SATCOUNT_EN
  logic [15:0] sat_count_q, sat_count_d;

  // Count saturated words alongside the flag. Clear has priority, and the count sticks at full scale.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (sat_flag_d && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`else
  logic unused_sat_clr;
  assign unused_sat_clr = sat_clr;
  assign sat_count      = '0;
`endif

endmodule
